rvv_backend_alu_result_buffer: RTL and testbench
================================================

# rvv_backend_alu_result_buffer

Buffers per-cycle results from the two ALU execution units (`ALU2ROB_t`, e.g. from the mask-logic unit) and delivers them to the ROB over a valid/ready handshake, one per cycle. It sits between the combinational ALU units and the ROB write port. Because the ALU units cannot stall once a uop is issued, the block returns a registered credit to the ALU reservation station. It absorbs ROB back-pressure without losing results and keeps them in age order.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥ 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `trap_flush_rvv`  in  1  synchronous flush; discards all buffered results.
- `alu_result_valid`  in  2  per-port result valid from ALU0/ALU1.
- `alu_result`  in  2 × `ALU2ROB_t`  per-port result; port 0 is older than port 1 in the same cycle.
- `alu_result_ready`  out  2  credit to the ALU RS. Bit 0 = at least 1 free entry; bit 1 = at least 2 free entries.
- `rob_valid`  out  1  head entry valid.
- `rob_data`  out  `ALU2ROB_t`  head entry contents.
- `rob_ready`  in  1  ROB accepts head this cycle.
- `buf_count`  out  $clog2(DEPTH)+1  occupied entries, for debug and perf.

## Operation
- State:
  - circular storage `mem[DEPTH]`;
  - `wptr` and `rptr`, $clog2(DEPTH) bits each, wrapping modulo DEPTH;
  - `count`, 0..DEPTH.
- Push:
  - `push0 = alu_result_valid[0] & alu_result_ready[0]`.
  - `push1 = alu_result_valid[1] & alu_result_ready[1]`.
  - Both pushes: port 0 goes to `mem[wptr]`, port 1 to `mem[wptr+1]`, and `wptr += 2`.
  - One push (either port): entry goes to `mem[wptr]`, `wptr += 1`. Port 1 alone is legal.
- Pop:
  - `pop = rob_valid & rob_ready`.
  - On pop, `rptr += 1`.
- Count update: `count_next = count + push0 + push1 − pop`.
- Outputs:
  - `rob_valid = (count != 0)`.
  - `rob_data = mem[rptr]`.
  - `buf_count = count`.
- Credit:
  - `alu_result_ready[0] = (count ≤ DEPTH−1)`.
  - `alu_result_ready[1] = (count ≤ DEPTH−2)`.
  - Both are taken from registered `count` only; a same-cycle pop does not raise credit.
- Illegal push: a valid port whose ready is low drops its result. Under `ASSERT_ON`, `rvv_expect` flags an error naming the port and `rob_entry`.
- Flush: `trap_flush_rvv=1` sets `wptr`, `rptr` and `count` to 0. It overrides any push and pop in the same cycle, and popped data in that cycle is not considered accepted.
- Payload: stored unmodified. That covers `rob_entry`, `w_data`, `w_valid`, `vxsat`, `ignore_vta` and `ignore_vma`; no field is recomputed.

## Timing
- Reset values (`rst_n=0`, asynchronous):
  - `wptr`, `rptr`, `count` = 0;
  - all `mem` entries = 0;
  - `rob_valid` = 0, `rob_data` = 0, `buf_count` = 0;
  - `alu_result_ready` = 2'b11.
- Latency: a result pushed at edge N is visible at `rob_data` in cycle N+1 if the buffer was empty; there is no bypass.
- Throughput: up to 2 pushes and 1 pop per cycle.
- Full: at `count == DEPTH`, ready = 2'b00; a pop in that cycle still occurs, and credit returns in the next cycle.
- `count == DEPTH−1`: ready = 2'b01. A simultaneous push0 and pop leaves `count` unchanged.
- Empty: `rob_ready` is ignored and `rptr` does not move.
- Wrap-around: pointer arithmetic is modulo DEPTH. A 2-entry push at `wptr = DEPTH−1` writes `mem[DEPTH−1]` and then `mem[0]`.
- Handshake: `rob_data` is stable while `rob_valid=1 & rob_ready=0`. Further pushes do not alter the head.
- Reset mid-operation: asynchronous clear to the reset values above; in-flight results are lost.

## Test plan
- Reset, then push0 `rob_entry=3` at cycle 1 with `rob_ready=1` → `rob_valid=1`, `rob_data.rob_entry=3` in cycle 2; `buf_count` goes 0→1→0.
- Dual push `rob_entry` 5 (port 0) and 6 (port 1), `rob_ready=0` for 3 cycles, then 1 → head is 5, stable for 3 cycles; then 5 and 6 pop on consecutive cycles.
- `DEPTH=4`, hold `rob_ready=0`, dual-push twice → `count=4` and `alu_result_ready=2'b00`. Then one pop → ready is 2'b00 in the pop cycle and 2'b01 the next.
- Pointer wrap: 7 single pushes interleaved with pops so that a dual push starts at `wptr=3` → FIFO order is preserved across the `mem[3]→mem[0]` wrap.
- Flush with `count=3`, simultaneous push0 and pop → next cycle `count=0`, `rob_valid=0`, ready = 2'b11.
- Assert `rst_n=0` asynchronously mid-burst with `count=2` → all outputs reach reset values before the next edge; no stale entry appears after reset release.

Source files
------------

// File: rtl/rvv_backend_alu_result_buffer.sv
// rtl/rvv_backend_alu_result_buffer.sv - in-order result buffer between the two ALU units and the ROB write port
// Accepts up to two results per cycle (port 0 older) and drains one per cycle to the ROB.

package rvv_alu_pkg;
    typedef struct packed {
        logic [3:0]  rob_entry;
        logic [31:0] w_data;
        logic [3:0]  w_valid;
        logic        vxsat;
        logic        ignore_vta;
        logic        ignore_vma;
    } ALU2ROB_t;
endpackage

module rvv_backend_alu_result_buffer
    import rvv_alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trap_flush_rvv,
    input  logic [1:0]                 alu_result_valid,
    input  ALU2ROB_t                   alu_result [2],
    output logic [1:0]                 alu_result_ready,
    output logic                       rob_valid,
    output ALU2ROB_t                   rob_data,
    input  logic                       rob_ready,
    output logic [$clog2(DEPTH):0]     buf_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ALU2ROB_t        mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wptr_plus1;
    logic            push0, push1, pop;

    // Credit is derived from registered occupancy only, so a same-cycle pop never raises it.
    assign alu_result_ready[0] = (count_q <= CW'(DEPTH - 1));
    assign alu_result_ready[1] = (count_q <= CW'(DEPTH - 2));

    assign push0      = alu_result_valid[0] & alu_result_ready[0];
    assign push1      = alu_result_valid[1] & alu_result_ready[1];
    assign rob_valid  = (count_q != '0);
    assign pop        = rob_valid & rob_ready;
    assign rob_data   = mem_q[rptr_q];
    assign buf_count  = count_q;
    assign wptr_plus1 = wptr_q + AW'(1);

    always_comb begin
        wptr_d  = wptr_q + AW'(push0) + AW'(push1);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + CW'(push0) + CW'(push1) - CW'(pop);
        if (trap_flush_rvv) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // A lone port-1 result takes the slot at wptr, keeping the storage dense.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!trap_flush_rvv) begin
            if (push0) begin
                mem_q[wptr_q] <= alu_result[0];
            end
            if (push1) begin
                mem_q[push0 ? wptr_plus1 : wptr_q] <= alu_result[1];
            end
        end
    end

`ifdef ASSERT_ON
`ifndef RVV_EXPECT
`define RVV_EXPECT(cond) assert (cond) else $error
`endif
    always @(posedge clk) begin
        if (rst_n) begin
            `RVV_EXPECT(!(alu_result_valid[0] && !alu_result_ready[0]))
                ("ALU port0 result dropped without credit, rob_entry=%0d", alu_result[0].rob_entry);
            `RVV_EXPECT(!(alu_result_valid[1] && !alu_result_ready[1]))
                ("ALU port1 result dropped without credit, rob_entry=%0d", alu_result[1].rob_entry);
        end
    end
`endif

endmodule

// File: tb/tb_rvv_backend_alu_result_buffer.sv
// tb/tb_rvv_backend_alu_result_buffer.sv - directed self-checking bench for the ALU result buffer
module tb_rvv_backend_alu_result_buffer;
    import rvv_alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trap_flush_rvv;
    logic [1:0] alu_result_valid;
    ALU2ROB_t   alu_result [2];
    logic [1:0] alu_result_ready;
    logic       rob_valid;
    ALU2ROB_t   rob_data;
    logic       rob_ready;
    logic [2:0] buf_count;

    int n_cmp = 0;
    int n_bad = 0;

    rvv_backend_alu_result_buffer #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .trap_flush_rvv   (trap_flush_rvv),
        .alu_result_valid (alu_result_valid),
        .alu_result       (alu_result),
        .alu_result_ready (alu_result_ready),
        .rob_valid        (rob_valid),
        .rob_data         (rob_data),
        .rob_ready        (rob_ready),
        .buf_count        (buf_count)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ALU2ROB_t mk(input logic [3:0] e);
        ALU2ROB_t r;
        r.rob_entry  = e;
        r.w_data     = {8{e}} ^ 32'hA5A5_0000;
        r.w_valid    = ~e;
        r.vxsat      = e[0];
        r.ignore_vta = e[1];
        r.ignore_vma = e[2];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [3:0] e0, input logic [3:0] e1);
        alu_result_valid = v;
        alu_result[0]    = mk(e0);
        alu_result[1]    = mk(e1);
    endtask

    task automatic check_state(input string tag, input logic [2:0] cnt, input logic [1:0] rdy,
                               input logic vld, input logic [3:0] head);
        expect_eq({tag, "_count"}, 64'(buf_count), 64'(cnt));
        expect_eq({tag, "_ready"}, 64'(alu_result_ready), 64'(rdy));
        expect_eq({tag, "_valid"}, 64'(rob_valid), 64'(vld));
        if (vld) begin
            expect_eq({tag, "_head"}, 64'(rob_data), 64'(mk(head)));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        trap_flush_rvv = 1'b0;
        rob_ready = 1'b0;
        drive(2'b00, 4'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1;
        expect_eq("rst_count", 64'(buf_count), 64'd0);
        expect_eq("rst_valid", 64'(rob_valid), 64'd0);
        expect_eq("rst_data", 64'(rob_data), 64'd0);
        expect_eq("rst_ready", 64'(alu_result_ready), 64'd3);
        rst_n = 1'b1;

        // single push, immediate drain
        drive(2'b01, 4'd3, 4'd0);
        rob_ready = 1'b1;
        tick();
        drive(2'b00, 4'd0, 4'd0);
        check_state("t1_push", 3'd1, 2'b11, 1'b1, 4'd3);
        tick();
        check_state("t1_pop", 3'd0, 2'b11, 1'b0, 4'd0);

        // dual push, head held under back-pressure
        rob_ready = 1'b0;
        drive(2'b11, 4'd5, 4'd6);
        tick();
        drive(2'b00, 4'd0, 4'd0);
        check_state("t2_hold0", 3'd2, 2'b11, 1'b1, 4'd5);
        tick();
        check_state("t2_hold1", 3'd2, 2'b11, 1'b1, 4'd5);
        tick();
        check_state("t2_hold2", 3'd2, 2'b11, 1'b1, 4'd5);
        rob_ready = 1'b1;
        tick();
        check_state("t2_pop5", 3'd1, 2'b11, 1'b1, 4'd6);
        tick();
        check_state("t2_pop6", 3'd0, 2'b11, 1'b0, 4'd0);

        // fill to DEPTH (wptr starts at 3, so the first pair wraps)
        rob_ready = 1'b0;
        drive(2'b11, 4'd7, 4'd8);
        tick();
        check_state("t3_fill2", 3'd2, 2'b11, 1'b1, 4'd7);
        drive(2'b11, 4'd9, 4'd10);
        tick();
        drive(2'b00, 4'd0, 4'd0);
        check_state("t3_full", 3'd4, 2'b00, 1'b1, 4'd7);
        rob_ready = 1'b1;
        #1;
        expect_eq("t3_popcycle_ready", 64'(alu_result_ready), 64'd0);
        tick();
        check_state("t3_after_pop", 3'd3, 2'b01, 1'b1, 4'd8);

        // count == DEPTH-1 with push0 and pop together
        drive(2'b01, 4'd11, 4'd0);
        tick();
        check_state("t4_push_pop", 3'd3, 2'b01, 1'b1, 4'd9);

        // flush overrides push and pop
        drive(2'b01, 4'd12, 4'd0);
        trap_flush_rvv = 1'b1;
        tick();
        trap_flush_rvv = 1'b0;
        drive(2'b00, 4'd0, 4'd0);
        check_state("t5_flush", 3'd0, 2'b11, 1'b0, 4'd0);

        // seven single pushes with concurrent pops, then a pair at wptr=3
        for (int k = 0; k < 7; k++) begin
            drive(2'b01, 4'(20 + k), 4'd0);
            tick();
            check_state($sformatf("t6_single%0d", k), 3'd1, 2'b11, 1'b1, 4'(20 + k));
        end
        rob_ready = 1'b0;
        drive(2'b11, 4'd14, 4'd15);
        tick();
        drive(2'b00, 4'd0, 4'd0);
        check_state("t6_pair", 3'd3, 2'b01, 1'b1, 4'(26));
        rob_ready = 1'b1;
        tick();
        check_state("t6_drain14", 3'd2, 2'b11, 1'b1, 4'd14);
        tick();
        check_state("t6_drain15", 3'd1, 2'b11, 1'b1, 4'd15);
        tick();
        check_state("t6_empty", 3'd0, 2'b11, 1'b0, 4'd0);

        // port 1 alone
        rob_ready = 1'b0;
        drive(2'b10, 4'd0, 4'd13);
        tick();
        drive(2'b00, 4'd0, 4'd0);
        check_state("t7_port1", 3'd1, 2'b11, 1'b1, 4'd13);

        // asynchronous reset mid-cycle
        drive(2'b11, 4'd1, 4'd2);
        tick();
        drive(2'b00, 4'd0, 4'd0);
        check_state("t8_pre", 3'd3, 2'b01, 1'b1, 4'd13);
        #3;
        rst_n = 1'b0;
        #1;
        expect_eq("t8_async_count", 64'(buf_count), 64'd0);
        expect_eq("t8_async_valid", 64'(rob_valid), 64'd0);
        expect_eq("t8_async_data", 64'(rob_data), 64'd0);
        expect_eq("t8_async_ready", 64'(alu_result_ready), 64'd3);
        tick();
        #3;
        rst_n = 1'b1;
        rob_ready = 1'b1;
        tick();
        check_state("t8_release", 3'd0, 2'b11, 1'b0, 4'd0);
        expect_eq("t8_release_data", 64'(rob_data), 64'd0);
        rob_ready = 1'b0;
        drive(2'b01, 4'd4, 4'd0);
        tick();
        drive(2'b00, 4'd0, 4'd0);
        check_state("t8_fresh", 3'd1, 2'b11, 1'b1, 4'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
